// File: rtl/ser16_tx.sv
// rtl/ser16_tx.sv - bit-serial 16-bit word transmitter (start, 16 data, optional parity, stop); parity enabled by SER16_PARITY_EN
module ser16_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [0:15] in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] DIV_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SER16_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, nstate;
    logic [15:0] div, ndiv;
    logic [4:0]  cnt, ncnt;
    logic [0:15] shift, nshift;
    logic        ntx;
    logic        div_end;
    logic        accept;
`ifdef SER16_PARITY_EN
    logic        par;
`endif

    assign div_end = (div == DIV_MAX);
    assign accept  = (state == IDLE) && in_valid;

    // Next-state, divider, bit counter and shift register; outputs are derived from the next state so they register cleanly
    always_comb begin
        nstate = state;
        ndiv   = div;
        ncnt   = cnt;
        nshift = shift;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    nstate = START;
                    ndiv   = '0;
                    ncnt   = '0;
                    nshift = in;
                end
            end
            START: begin
                if (div_end) begin
                    nstate = DATA;
                    ndiv   = '0;
                    ncnt   = '0;
                end else begin
                    ndiv = div + 16'd1;
                end
            end
            DATA: begin
                if (div_end) begin
                    ndiv   = '0;
                    nshift = {shift[1:15], 1'b0};
                    if (cnt == 5'd15) begin
`ifdef SER16_PARITY_EN
                        nstate = PARITY;
`else
                        nstate = STOP;
`endif
                    end else begin
                        ncnt = cnt + 5'd1;
                    end
                end else begin
                    ndiv = div + 16'd1;
                end
            end
`ifdef SER16_PARITY_EN
            PARITY: begin
                if (div_end) begin
                    nstate = STOP;
                    ndiv   = '0;
                end else begin
                    ndiv = div + 16'd1;
                end
            end
`endif
            STOP: begin
                if (div_end) begin
                    nstate = IDLE;
                    ndiv   = '0;
                end else begin
                    ndiv = div + 16'd1;
                end
            end
            default: begin
                nstate = IDLE;
                ndiv   = '0;
            end
        endcase
    end

    // Line level that the next state will drive
    always_comb begin
        ntx = 1'b1;
        unique case (nstate)
            START:   ntx = 1'b0;
            DATA:    ntx = nshift[0];
`ifdef SER16_PARITY_EN
            PARITY:  ntx = par;
`endif
            default: ntx = 1'b1;
        endcase
    end

    // FSM state and registered outputs; reset forces the line high without waiting for a clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div      <= '0;
            cnt      <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SER16_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= nstate;
            div      <= ndiv;
            cnt      <= ncnt;
            shift    <= nshift;
            tx       <= ntx;
            in_ready <= (nstate == IDLE);
            busy     <= (nstate != IDLE);
            done     <= (nstate == STOP) && (ndiv == DIV_MAX);
`ifdef SER16_PARITY_EN
            if (accept) begin
                par <= ^in;
            end
`endif
        end
    end

endmodule

// File: doc/ser16_tx.md
# ser16_tx

Bit-serial transmitter for 16-bit words. It accepts one parallel word per valid/ready handshake and shifts it out on a single line as a framed serial stream: start bit, 16 data bits, optional parity bit, stop bit. It sits between the parallel 16-bit datapath and an off-block serial link, and pairs with the serial-to-parallel receiver at the far end of that link.

## Interface
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..65535
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous reset, active-low
- in  in  [0:15]  word to send; index 0 is transmitted first
- in_valid  in  1  `in` holds a word to send
- in_ready  out  1  block can accept a word this cycle
- tx  out  1  serial line; idles high
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse on the last cycle of the stop bit

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro defined), STOP.
- Reset values, applied asynchronously while reset_n=0:
  - state=IDLE
  - tx=1, in_ready=1, busy=0, done=0
  - shift register, bit counter and divider all cleared
- IDLE:
  - in_ready=1, tx=1.
  - Accept occurs on a rising edge with in_valid=1 and in_ready=1.
  - On accept: `in` is latched into the shift register, the divider resets to 0, and the state becomes START.
  - When in_valid=0, nothing changes.
- Transitions between frame states use a divider counting 0..CLKS_PER_BIT-1. The state advances when the divider reaches CLKS_PER_BIT-1, and the divider then wraps to 0.
- START: tx=0.
- DATA:
  - tx = current shift-register head, beginning with in[0].
  - The register shifts by one position per bit period.
  - A 5-bit counter counts 16 bit periods.
  - Exit goes to PARITY if enabled, otherwise STOP.
- PARITY: tx = XOR of the 16 latched bits, giving even parity over data plus parity.
- STOP:
  - tx=1.
  - done=1 during the final clock of the stop bit only.
  - The next state is IDLE.
- busy=1 and in_ready=0 in every state except IDLE.
- `in` and in_valid are ignored while busy. The latched copy is unaffected by later changes to `in`.
- tx is registered and glitch-free.

## Timing
- Accept edge at cycle N: tx falls to 0 at cycle N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length from first start-bit cycle to last stop-bit cycle:
  - 18·CLKS_PER_BIT cycles without parity.
  - 19·CLKS_PER_BIT cycles with parity.
- done is asserted in the last frame cycle. State is IDLE and in_ready=1 on the following cycle.
- Back-to-back: holding in_valid=1 gives 1 idle-high cycle between frames (the accept cycle).
- CLKS_PER_BIT=1:
  - Every frame state lasts exactly one cycle.
  - The divider is constant 0.
- Reset asserted mid-frame:
  - tx returns to 1 immediately, without waiting for a clock.
  - The frame is abandoned and done does not pulse.
  - After release the block is in IDLE.
- Simultaneous in_valid and done: no accept that cycle, because in_ready=0. Accept happens on the next cycle.

## Configuration
- SER16_PARITY_EN defined:
  - The PARITY state is present.
  - Frames are 19 bits, with the even-parity bit sent between data bit 15 and the stop bit.
- SER16_PARITY_EN undefined:
  - The PARITY state and XOR tree are compiled out.
  - Frames are 18 bits; STOP directly follows DATA.
- The port list is identical in both builds.

## Test plan
- Reset: hold reset_n=0 for 3 cycles -> tx=1, in_ready=1, busy=0, done=0. Then assert reset_n=0 mid-DATA -> tx=1 asynchronously, no done, IDLE after release.
- Basic frame, CLKS_PER_BIT=4, no parity, in=16'hA5C3:
  - tx sequence per 4-cycle bit: 0, then 1010010111000011, then 1.
  - done pulses on the 72nd frame cycle.
  - in_ready=1 on the next cycle.
- Parity, SER16_PARITY_EN defined, CLKS_PER_BIT=2:
  - in=16'h0001 -> parity bit 1, frame 38 cycles.
  - in=16'hA5C3 -> parity bit 0.
- Back-to-back with CLKS_PER_BIT=1 and in_valid held high, words 16'hFFFF then 16'h0000:
  - Two 18-cycle frames separated by exactly one tx=1 idle cycle.
  - done pulses twice.
- Input stability: change `in` to 16'h1234 every cycle during a frame of 16'hA5C3 -> transmitted bits remain 1010010111000011.
- Stall: in_valid=0 for 10 cycles -> tx=1, busy=0, no done.
